// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int MEM_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arbStateT;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } ownerT;

endpackage

// File: rtl/mem_arb_cnt.sv
// Access latency counter: loads at grant and counts down to zero without wrapping.
// The zero flag marks the last cycle of an access.
module mem_arb_cnt
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] loadVal,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 3'd0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != 3'd0)) begin
            count <= count - 3'd1;
        end
    end

    assign zero = (count == 3'd0);

endmodule

// File: rtl/mem_arb.sv
// Arbitrates fetch and data-memory requests onto one single-port memory.
// Fixed priority (data wins) by default; define MEM_ARB_RR_EN for round-robin.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_ready,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [2:0] LOAD_VAL = 3'(MEM_LAT - 1);

    arbStateT state;
    ownerT    owner;
    logic     grantDm;
    logic     anyReq;
    logic     cntZero;
`ifdef MEM_ARB_RR_EN
    ownerT    lastOwner;
`endif

    assign anyReq = if_req | dm_req;

    // With round-robin, a tie goes to whoever was not served last.
    always_comb begin
        grantDm = dm_req;
`ifdef MEM_ARB_RR_EN
        if (dm_req && if_req) begin
            grantDm = (lastOwner == OWN_IF);
        end
`endif
    end

    mem_arb_cnt uCnt (
        .clk     (clk),
        .rst     (rst),
        .load    ((state == IDLE) && anyReq),
        .loadVal (LOAD_VAL),
        .dec     (state == ACCESS),
        .zero    (cntZero)
    );

    // Request fields are latched at grant so later requester changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            if_rdata  <= 16'h0000;
            dm_rdata  <= 16'h0000;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            lastOwner <= OWN_IF;
`endif
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        state     <= ACCESS;
                        owner     <= grantDm ? OWN_DM : OWN_IF;
                        mem_en    <= 1'b1;
                        mem_wr    <= grantDm & dm_wr;
                        mem_addr  <= grantDm ? dm_addr : if_addr;
                        mem_wdata <= grantDm ? dm_wdata : 16'h0000;
`ifdef MEM_ARB_RR_EN
                        lastOwner <= grantDm ? OWN_DM : OWN_IF;
`endif
                    end
                end
                ACCESS: begin
                    if (cntZero) begin
                        state  <= DONE;
                        mem_en <= 1'b0;
                        mem_wr <= 1'b0;
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            if (!mem_wr) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;

endmodule
